key_event_decoder: RTL
======================

Name: key_event_decoder

Overview:
- Converts the raw 16-bit USB keyboard keycode into single-cycle game action pulses: rotate, left, right, soft drop, hard drop.
- Left, right and soft drop auto-repeat in frame ticks (delayed auto-shift); rotate and hard drop fire once per press.
- Sits directly upstream of the rotation FSM and the piece-movement logic, replacing raw keycode comparisons in those blocks.

Parameters:
- DAS_FRAMES, 10: frame ticks from the initial left/right pulse to the first repeat.
- ARR_FRAMES, 3: frame ticks between left/right repeats.
- SOFT_FRAMES, 2: frame ticks between soft-drop repeats; no initial delay.
- KEY_ROT, 8'h1A: rotate key, W.
- KEY_LEFT, 8'h04: left key, A.
- KEY_RIGHT, 8'h07: right key, D.
- KEY_DOWN, 8'h16: soft drop key, S.
- KEY_DROP, 8'h2C: hard drop key, Space.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- keycode  in  16  two HID key slots, [7:0] and [15:8], in the Clk domain; 8'h00 means empty slot.
- frame_tick  in  1  one-Clk pulse per video frame.
- enable  in  1  game active; low suppresses all outputs and idles all FSMs.
- rot_pulse  out  1  one-Clk rotate request.
- left_pulse  out  1  one-Clk move-left request.
- right_pulse  out  1  one-Clk move-right request.
- down_pulse  out  1  one-Clk soft-drop request.
- drop_pulse  out  1  one-Clk hard-drop request.
- held  out  5  level: {drop,down,right,left,rot} pressed after filtering.

Behaviour:
- Reset: all outputs 0, all FSMs IDLE, all counters 0, key register 0.
- keycode is registered once into key_q.
- A key counts as pressed when either slot of key_q equals its code.
- All outputs are registered. Latency from keycode change to pulse is 2 Clk cycles.
- rot and drop: rising-edge detect on pressed. Exactly one pulse per press, regardless of hold length. Release and re-press gives a new pulse.
- left, right and down each use a repeat FSM with states IDLE, DELAY, REPEAT.
  - IDLE, pressed: pulse now, counter cleared, go to DELAY. Down goes straight to REPEAT.
  - DELAY: counter increments on frame_tick. When it reaches DAS_FRAMES: pulse, clear counter, go to REPEAT.
  - REPEAT: counter increments on frame_tick. When it reaches ARR_FRAMES (SOFT_FRAMES for down): pulse, clear counter.
  - Any state, not pressed: go to IDLE and clear counter the same cycle. No pulse on release.
- A frame_tick coinciding with the press cycle is not counted.
- Counter width is $clog2(max(DAS_FRAMES, ARR_FRAMES, SOFT_FRAMES)+1). The counter never wraps.
- Left and right held together: both are treated as not pressed. Both FSMs are forced to IDLE and no pulses are issued.
  - Releasing one key makes the other a fresh press on the next cycle: immediate pulse, then DAS restarts.
- Down and hard drop held together: drop_pulse fires once; down repeat continues independently.
- Two different keys rising in the same cycle each pulse in that cycle. Outputs are not prioritised; the consumer arbitrates.
- enable low: outputs and held forced to 0, FSMs to IDLE, edge detectors loaded with current pressed.
  - Therefore keys already held when enable rises do not pulse until released and re-pressed.
- Reset_n asserted mid-hold: immediate return to reset values. After deassertion, a still-held key pulses once because the edge register cleared to 0.
- Duplicate code in both slots counts as a single press.

Decomposition:
- Package tetris_keys_pkg holds:
  - the five keycode constants;
  - the repeat-state enum {REP_IDLE, REP_DELAY, REP_REPEAT};
  - a function that matches an 8-bit code against both slots of a 16-bit keycode.
- Sub-module key_repeat (params DELAY, RATE, USE_DELAY): Clk, Reset_n, pressed, frame_tick, clear -> pulse. Instantiated three times.
- Rotate and drop edge detectors are inline.

Test Plan:
- Reset_n low, keycode=16'h001A -> all outputs 0. Release reset with W held -> rot_pulse high for exactly 1 cycle, 2 cycles after release.
- keycode 16'h0000 -> 16'h001A held for 50 ticks, then 16'h0000, then 16'h1A00 -> exactly 2 rot_pulses; the second comes from slot [15:8].
- keycode=16'h0004 held for 19 ticks (DAS 10, ARR 3) -> left_pulse at press, at tick 10, then ticks 13 and 16, then tick 19: 5 pulses total.
- A held, then keycode=16'h0704 -> no left or right pulses while both held. Then keycode=16'h0007 -> right_pulse 2 cycles later, next at tick 10.
- keycode=16'h0016 held for 6 ticks -> down_pulse at press and at ticks 2, 4 and 6. Adding Space (16'h2C16) -> one drop_pulse while down keeps repeating.
- enable=0 while D held, then enable=1 -> no right_pulse. After release and re-press -> right_pulse.

Source files
------------

// File: rtl/tetris_keys_pkg.sv
// Shared keycodes, repeat-FSM state type and the two-slot HID key matcher.
package tetris_keys_pkg;

   localparam logic [7:0] KEY_ROT   = 8'h1A;
   localparam logic [7:0] KEY_LEFT  = 8'h04;
   localparam logic [7:0] KEY_RIGHT = 8'h07;
   localparam logic [7:0] KEY_DOWN  = 8'h16;
   localparam logic [7:0] KEY_DROP  = 8'h2C;

   typedef enum logic [1:0] {
      REP_IDLE,
      REP_DELAY,
      REP_REPEAT
   } rep_state_t;

   // A key is down when either HID slot carries its code; a duplicate still counts once.
   function automatic logic key_match(input logic [15:0] kc, input logic [7:0] code);
      return (kc[7:0] == code) || (kc[15:8] == code);
   endfunction

endpackage

// File: rtl/key_repeat.sv
// Auto-repeat FSM: pulse on press, optional initial delay, then fixed-rate repeat in frame ticks.
// Latency 1 Clk from pressed to pulse; no backpressure, the pulse is a one-cycle request.
module key_repeat
   import tetris_keys_pkg::*;
#(
   parameter int DELAY     = 10,
   parameter int RATE      = 3,
   parameter bit USE_DELAY = 1'b1
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic pressed,
   input  logic frame_tick,
   input  logic clear,
   output logic pulse
);

   localparam int MAXV = (DELAY > RATE) ? DELAY : RATE;
   localparam int CW   = $clog2(MAXV + 1);
   localparam logic [CW-1:0] DELAY_C = CW'(DELAY);
   localparam logic [CW-1:0] RATE_C  = CW'(RATE);

   rep_state_t    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_block;
   logic [CW-1:0] w_cnt_inc;

   assign w_cnt_inc = r_cnt + CW'(1);

   // r_block keeps a key that was already held while cleared from firing until it is released.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= REP_IDLE;
         r_cnt   <= '0;
         r_block <= 1'b0;
         pulse   <= 1'b0;
      end else if (clear) begin
         r_state <= REP_IDLE;
         r_cnt   <= '0;
         r_block <= pressed;
         pulse   <= 1'b0;
      end else if (!pressed) begin
         r_state <= REP_IDLE;
         r_cnt   <= '0;
         r_block <= 1'b0;
         pulse   <= 1'b0;
      end else begin
         pulse <= 1'b0;
         case (r_state)
            REP_IDLE: begin
               if (!r_block) begin
                  pulse   <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= USE_DELAY ? REP_DELAY : REP_REPEAT;
               end
            end
            REP_DELAY: begin
               if (frame_tick) begin
                  if (w_cnt_inc == DELAY_C) begin
                     pulse   <= 1'b1;
                     r_cnt   <= '0;
                     r_state <= REP_REPEAT;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
            end
            REP_REPEAT: begin
               if (frame_tick) begin
                  if (w_cnt_inc == RATE_C) begin
                     pulse <= 1'b1;
                     r_cnt <= '0;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
            end
            default: begin
               r_state <= REP_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_event_decoder.sv
// Turns the raw two-slot HID keycode into one-cycle game action pulses plus a filtered held level.
// Latency 2 Clk from keycode change to pulse; no backpressure, the consumer arbitrates pulses.
module key_event_decoder
   import tetris_keys_pkg::*;
#(
   parameter int DAS_FRAMES  = 10,
   parameter int ARR_FRAMES  = 3,
   parameter int SOFT_FRAMES = 2
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [15:0] keycode,
   input  logic        frame_tick,
   input  logic        enable,
   output logic        rot_pulse,
   output logic        left_pulse,
   output logic        right_pulse,
   output logic        down_pulse,
   output logic        drop_pulse,
   output logic [4:0]  held
);

   logic [15:0] r_key_q;
   logic        r_rot_prev;
   logic        r_drop_prev;

   logic w_rot_hit, w_left_hit, w_right_hit, w_down_hit, w_drop_hit;
   logic w_left_p, w_right_p;
   logic w_clear;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_key_q <= '0;
      else          r_key_q <= keycode;
   end

   assign w_rot_hit   = key_match(r_key_q, KEY_ROT);
   assign w_left_hit  = key_match(r_key_q, KEY_LEFT);
   assign w_right_hit = key_match(r_key_q, KEY_RIGHT);
   assign w_down_hit  = key_match(r_key_q, KEY_DOWN);
   assign w_drop_hit  = key_match(r_key_q, KEY_DROP);

   // Opposing directions cancel; dropping one leaves the other as a fresh press.
   assign w_left_p  = w_left_hit & ~w_right_hit;
   assign w_right_p = w_right_hit & ~w_left_hit;
   assign w_clear   = ~enable;

   // Edge registers track pressed even while disabled, so keys held across enable do not fire.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_rot_prev  <= 1'b0;
         r_drop_prev <= 1'b0;
         rot_pulse   <= 1'b0;
         drop_pulse  <= 1'b0;
         held        <= '0;
      end else begin
         r_rot_prev  <= w_rot_hit;
         r_drop_prev <= w_drop_hit;
         if (enable) begin
            rot_pulse  <= w_rot_hit & ~r_rot_prev;
            drop_pulse <= w_drop_hit & ~r_drop_prev;
            held       <= {w_drop_hit, w_down_hit, w_right_p, w_left_p, w_rot_hit};
         end else begin
            rot_pulse  <= 1'b0;
            drop_pulse <= 1'b0;
            held       <= '0;
         end
      end
   end

   key_repeat #(
      .DELAY     (DAS_FRAMES),
      .RATE      (ARR_FRAMES),
      .USE_DELAY (1'b1)
   ) u_left (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .pressed    (w_left_p),
      .frame_tick (frame_tick),
      .clear      (w_clear),
      .pulse      (left_pulse)
   );

   key_repeat #(
      .DELAY     (DAS_FRAMES),
      .RATE      (ARR_FRAMES),
      .USE_DELAY (1'b1)
   ) u_right (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .pressed    (w_right_p),
      .frame_tick (frame_tick),
      .clear      (w_clear),
      .pulse      (right_pulse)
   );

   key_repeat #(
      .DELAY     (DAS_FRAMES),
      .RATE      (SOFT_FRAMES),
      .USE_DELAY (1'b0)
   ) u_down (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .pressed    (w_down_hit),
      .frame_tick (frame_tick),
      .clear      (w_clear),
      .pulse      (down_pulse)
   );

endmodule
